// File: rtl/click_record_buffer_pkg.sv
// click_record_buffer_pkg: shared widths, serialiser state encoding and frame builder
// for the click record buffer.
package click_record_buffer_pkg;
    localparam int REC_W   = 44;
    localparam int WORD_W  = 16;
    localparam int FRAME_W = 48;
    localparam int ENTRY_W = REC_W + 1;
    localparam logic [15:0] LOST_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } state_t;

    // Stored entry is {lost_bit, record}; the frame pads it to three whole words.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [ENTRY_W-1:0] entry);
        return {entry[ENTRY_W-1], 3'b000, entry[REC_W-1:0]};
    endfunction
endpackage

// File: rtl/click_record_buffer_fifo.sv
// click_record_buffer_fifo: synchronous first-word-fall-through FIFO with occupancy level.
module click_record_buffer_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int W          = 45
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wr_en,
    input  logic [W-1:0]          i_wr_data,
    input  logic                  i_rd_en,
    output logic [W-1:0]          o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level
);
    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [W-1:0]        r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] r_wr_cnt;
    logic [DEPTH_LOG2:0] r_rd_cnt;
    logic                w_wr;
    logic                w_rd;

    assign o_level   = r_wr_cnt - r_rd_cnt;
    assign o_full    = o_level == DEPTH;
    assign o_empty   = o_level == '0;
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_cnt[DEPTH_LOG2-1:0]];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_wr_cnt <= r_wr_cnt + {{DEPTH_LOG2{1'b0}}, w_wr};
            r_rd_cnt <= r_rd_cnt + {{DEPTH_LOG2{1'b0}}, w_rd};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_cnt[DEPTH_LOG2-1:0]] <= i_wr_data;
    end
endmodule

// File: rtl/click_record_buffer.sv
// click_record_buffer: buffers 44-bit click records, counts overflow drops and
// serialises each record as three 16-bit words under a valid/ack handshake.
module click_record_buffer
    import click_record_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [REC_W-1:0]     i_rec_data,
    input  logic                 i_rec_ready,
    output logic [WORD_W-1:0]    o_out_word,
    output logic                 o_out_valid,
    input  logic                 i_out_ack,
    output logic [DEPTH_LOG2:0]  o_fifo_level,
    output logic                 o_overflow,
    output logic [15:0]          o_lost_count
);
    state_t               r_state;
    state_t               w_state_nxt;
    logic [FRAME_W-1:0]   r_frame;
    logic [WORD_W-1:0]    r_out_word;
    logic                 r_overflow;
    logic                 r_lost_flag;
    logic [15:0]          r_lost_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr;
    logic                 w_drop;
    logic                 w_pop;
    logic [ENTRY_W-1:0]   w_head;
    logic [FRAME_W-1:0]   w_new_frame;

    // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
    assign w_wr        = i_rec_ready && !w_full;
    assign w_drop      = i_rec_ready && w_full;
    assign w_new_frame = make_frame(w_head);

    click_record_buffer_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          (ENTRY_W)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_wr_en    (w_wr),
        .i_wr_data  ({r_lost_flag, i_rec_data}),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (o_fifo_level)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pop       = !w_empty;
                w_state_nxt = w_empty ? ST_IDLE : ST_W0;
            end
            ST_W0: w_state_nxt = i_out_ack ? ST_W1 : ST_W0;
            ST_W1: w_state_nxt = i_out_ack ? ST_W2 : ST_W1;
            ST_W2: begin
                w_pop       = i_out_ack && !w_empty;
                w_state_nxt = !i_out_ack ? ST_W2 : (w_empty ? ST_IDLE : ST_W0);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_frame      <= '0;
            r_out_word   <= '0;
            r_overflow   <= 1'b0;
            r_lost_flag  <= 1'b0;
            r_lost_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_overflow <= w_drop;
            if (w_pop) begin
                r_frame    <= w_new_frame;
                r_out_word <= w_new_frame[47:32];
            end else if (i_out_ack && r_state == ST_W0) begin
                r_out_word <= r_frame[31:16];
            end else if (i_out_ack && r_state == ST_W1) begin
                r_out_word <= r_frame[15:0];
            end
            if (w_drop) begin
                r_lost_flag <= 1'b1;
            end else if (w_wr) begin
                r_lost_flag <= 1'b0;
            end
            if (w_drop && r_lost_count != LOST_SAT) r_lost_count <= r_lost_count + 16'd1;
        end
    end

    assign o_out_valid  = r_state != ST_IDLE;
    assign o_out_word   = r_out_word;
    assign o_overflow   = r_overflow;
    assign o_lost_count = r_lost_count;
endmodule

// File: tb/tb_click_record_buffer.sv
// tb_click_record_buffer: directed and randomized checks of click_record_buffer against
// a queue-based reference model of the record buffer and word serialiser.
module tb_click_record_buffer;
    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [43:0] i_rec_data = '0;
    logic        i_rec_ready = 1'b0;
    logic        i_out_ack = 1'b0;
    logic [15:0] o_out_word;
    logic        o_out_valid;
    logic [4:0]  o_fifo_level;
    logic        o_overflow;
    logic [15:0] o_lost_count;

    int checks = 0;
    int errors = 0;

    logic [44:0] mq[$];
    int          m_idx;
    logic [47:0] m_frame;
    logic [15:0] m_word;
    logic        m_ovf;
    logic        m_lost;
    logic [15:0] m_cnt;

    click_record_buffer #(.DEPTH_LOG2(4)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_rec_data   (i_rec_data),
        .i_rec_ready  (i_rec_ready),
        .o_out_word   (o_out_word),
        .o_out_valid  (o_out_valid),
        .i_out_ack    (i_out_ack),
        .o_fifo_level (o_fifo_level),
        .o_overflow   (o_overflow),
        .o_lost_count (o_lost_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_idx = -1;
        m_frame = '0;
        m_word = '0;
        m_ovf = 1'b0;
        m_lost = 1'b0;
        m_cnt = '0;
    endtask

    // One clock of the reference: finish/advance the current frame, then accept or drop.
    task automatic model_edge(input logic rr, input logic [43:0] d, input logic ack);
        bit full = mq.size() == 16;
        bit pop = 0;
        logic [44:0] e;
        if (m_idx < 0) pop = mq.size() != 0;
        else if (ack) begin
            if (m_idx < 2) begin
                m_idx++;
                m_word = m_frame[47 - 16*m_idx -: 16];
            end else begin
                pop = mq.size() != 0;
                if (!pop) m_idx = -1;
            end
        end
        if (pop) begin
            e = mq.pop_front();
            m_frame = {e[44], 3'b000, e[43:0]};
            m_idx = 0;
            m_word = m_frame[47:32];
        end
        m_ovf = rr && full;
        if (rr) begin
            if (full) begin
                m_lost = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt++;
            end else begin
                mq.push_back({m_lost, d});
                m_lost = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("valid", 48'(o_out_valid), 48'(m_idx >= 0));
        chk("word", 48'(o_out_word), 48'(m_word));
        chk("level", 48'(o_fifo_level), 48'(mq.size()));
        chk("overflow", 48'(o_overflow), 48'(m_ovf));
        chk("lost_count", 48'(o_lost_count), 48'(m_cnt));
    endtask

    task automatic step(input logic rr, input logic [43:0] d, input logic ack);
        i_rec_ready = rr;
        i_rec_data = d;
        i_out_ack = ack;
        @(posedge i_clk);
        model_edge(rr, d, ack);
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_rec_ready = 1'b0;
        i_out_ack = 1'b0;
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        compare_all();
    endtask

    initial begin
        int ovf_pulses;
        logic [43:0] d;
        model_reset();
        do_reset();
        chk("reset_valid", 48'(o_out_valid), 48'd0);
        chk("reset_word", 48'(o_out_word), 48'd0);
        chk("reset_level", 48'(o_fifo_level), 48'd0);

        // Single record, continuous ack.
        step(1'b1, 44'h987_6543_210F, 1'b1);
        chk("t1_latency_idle", 48'(o_out_valid), 48'd0);
        step(1'b0, 44'h0, 1'b1);
        chk("t1_w0", 48'({o_out_valid, o_out_word}), 48'h1_0987);
        step(1'b0, 44'h0, 1'b1);
        chk("t1_w1", 48'({o_out_valid, o_out_word}), 48'h1_6543);
        step(1'b0, 44'h0, 1'b1);
        chk("t1_w2", 48'({o_out_valid, o_out_word}), 48'h1_210F);
        step(1'b0, 44'h0, 1'b1);
        chk("t1_done", 48'(o_out_valid), 48'd0);

        // Backpressure held in W1.
        step(1'b1, 44'h987_6543_210F, 1'b0);
        step(1'b0, 44'h0, 1'b0);
        step(1'b0, 44'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 44'h0, 1'b0);
            chk("t2_hold_w1", 48'({o_out_valid, o_out_word}), 48'h1_6543);
        end
        step(1'b0, 44'h0, 1'b1);
        chk("t2_resume_w2", 48'({o_out_valid, o_out_word}), 48'h1_210F);
        step(1'b0, 44'h0, 1'b1);
        chk("t2_done", 48'(o_out_valid), 48'd0);

        // Overflow: one record parked in W0, then 20 back-to-back strobes.
        step(1'b1, 44'h111_2222_3333, 1'b0);
        step(1'b0, 44'h0, 1'b0);
        ovf_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 44'(i + 1), 1'b0);
            ovf_pulses += int'(o_overflow);
        end
        step(1'b0, 44'h0, 1'b0);
        ovf_pulses += int'(o_overflow);
        chk("t3_level", 48'(o_fifo_level), 48'd16);
        chk("t3_pulses", 48'(ovf_pulses), 48'd4);
        chk("t3_lost", 48'(o_lost_count), 48'd4);
        for (int i = 0; i < 52; i++) step(1'b0, 44'h0, 1'b1);
        chk("t3_drained", 48'({o_out_valid, o_fifo_level}), 48'd0);
        step(1'b1, 44'h0, 1'b1);
        step(1'b0, 44'h0, 1'b1);
        chk("t3_lost_bit_w0", 48'({o_out_valid, o_out_word}), 48'h1_8000);
        for (int i = 0; i < 3; i++) step(1'b0, 44'h0, 1'b1);

        // Saturation of the lost counter.
        do_reset();
        for (int i = 0; i < 17 + 65540; i++) step(1'b1, 44'(i), 1'b0);
        chk("t4_sat", 48'(o_lost_count), 48'hFFFF);
        chk("t4_level", 48'(o_fifo_level), 48'd16);

        // Streaming: 10 records back to back, 30 words with no gap.
        do_reset();
        for (int i = 0; i < 31; i++) begin
            d = {12'($urandom), $urandom};
            step(i < 10, d, 1'b1);
            if (i >= 1) chk("t5_continuous", 48'(o_out_valid), 48'd1);
        end
        step(1'b0, 44'h0, 1'b1);
        chk("t5_end", 48'({o_out_valid, o_fifo_level}), 48'd0);

        // Asynchronous reset in the middle of a frame.
        step(1'b1, 44'hABC_DEF0_1234, 1'b0);
        step(1'b1, 44'h555_6666_7777, 1'b0);
        step(1'b0, 44'h0, 1'b1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("t6_async_valid", 48'(o_out_valid), 48'd0);
        chk("t6_async_level", 48'(o_fifo_level), 48'd0);
        chk("t6_async_lost", 48'(o_lost_count), 48'd0);
        model_reset();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        step(1'b1, 44'h321_4321_5432, 1'b1);
        step(1'b0, 44'h0, 1'b1);
        chk("t6_new_w0", 48'({o_out_valid, o_out_word}), 48'h1_0321);

        // Randomized traffic with frequent backpressure to exercise drops and wrap.
        for (int i = 0; i < 3000; i++) begin
            d = {12'($urandom), $urandom};
            step($urandom_range(0, 9) < 6, d, $urandom_range(0, 9) < 3);
        end
        for (int i = 0; i < 60; i++) step(1'b0, 44'h0, 1'b1);
        chk("rand_drained", 48'({o_out_valid, o_fifo_level}), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
